// File: rtl/irq_scheduler_if.sv
// rtl/irq_scheduler_if.sv - table-write, playback-control and status signals of irq_scheduler
interface irq_scheduler_if #(
  parameter int NLINES = 32,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 32,
  parameter int LEN_W  = 8
) ();
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(NLINES);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [CNT_W-1:0]  wr_time;
  logic [LW-1:0]     wr_line;
  logic [LEN_W-1:0]  wr_len;
  logic [AW-1:0]     first;
  logic [AW-1:0]     last;
  logic              start;
  logic              abort;
  logic [NLINES-1:0] irqs;
  logic              busy;
  logic              done;
  logic              fired;
  logic [AW-1:0]     ptr;

  modport master (
    output wr_en, wr_addr, wr_time, wr_line, wr_len, first, last, start, abort,
    input  irqs, busy, done, fired, ptr
  );

  modport slave (
    input  wr_en, wr_addr, wr_time, wr_line, wr_len, first, last, start, abort,
    output irqs, busy, done, fired, ptr
  );
endinterface

// File: rtl/irq_scheduler.sv
// rtl/irq_scheduler.sv - table-driven interrupt pulse generator with per-line retriggerable pulse counters
module irq_scheduler #(
  parameter int NLINES    = 32,
  parameter int DEPTH     = 1024,
  parameter int CNT_W     = 32,
  parameter int LEN_W     = 8,
  parameter int DEF_PULSE = 2
) (
  input logic           clk,
  input logic           reset,
  irq_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(NLINES);
  localparam int EW = CNT_W + LW + LEN_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                        state_q, state_d;
  logic [AW-1:0]                 ptr_q, ptr_d;
  logic [AW-1:0]                 lastq_q, lastq_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [NLINES-1:0][LEN_W-1:0]  ctr_q, ctr_d;
  logic [NLINES-1:0]             irqs_q, irqs_d;
  logic                          fired_q, fired_d;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    ent;
  logic [CNT_W-1:0] e_time;
  logic [LW-1:0]    e_line;
  logic [LEN_W-1:0] e_len;
  logic [LEN_W-1:0] e_len_eff;
  logic             due;

  // Table is never cleared; reset only blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset && bus.wr_en) begin
      mem[bus.wr_addr] <= {bus.wr_time, bus.wr_line, bus.wr_len};
    end
  end

  assign ent                      = mem[ptr_q];
  assign {e_time, e_line, e_len}  = ent;
  assign e_len_eff                = (e_len == '0) ? LEN_W'(DEF_PULSE) : e_len;
  assign due                      = (state_q == RUN) && (e_time <= count_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lastq_d = lastq_q;
    count_d = count_q;
    fired_d = 1'b0;
    for (int i = 0; i < NLINES; i++) begin
      ctr_d[i] = (ctr_q[i] != '0) ? ctr_q[i] - LEN_W'(1) : '0;
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          ptr_d   = bus.first;
          lastq_d = bus.last;
          count_d = '0;
          state_d = (bus.first > bus.last) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          ctr_d   = '0;
          state_d = IDLE;
        end else begin
          if (count_q != '1) count_d = count_q + CNT_W'(1);
          // A due entry reloads its line rather than extending it.
          if (due) begin
            ctr_d[e_line] = e_len_eff;
            fired_d       = 1'b1;
            if (ptr_q == lastq_q) state_d = DRAIN;
            else                  ptr_d   = ptr_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          ctr_d   = '0;
          state_d = IDLE;
        end else if (ctr_q == '0) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NLINES; i++) begin
      irqs_d[i] = (ctr_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lastq_q <= '0;
      count_q <= '0;
      ctr_q   <= '0;
      irqs_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lastq_q <= lastq_d;
      count_q <= count_d;
      ctr_q   <= ctr_d;
      irqs_q  <= irqs_d;
      fired_q <= fired_d;
    end
  end

  assign bus.irqs  = irqs_q;
  assign bus.busy  = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done  = (state_q == DONE);
  assign bus.fired = fired_q;
  assign bus.ptr   = ptr_q;
endmodule

// File: tb/tb_irq_scheduler.sv
// tb/tb_irq_scheduler.sv - scenario table and scoreboard bench for irq_scheduler
module tb_irq_scheduler;
  localparam int NL = 32;
  localparam int DP = 16;
  localparam int CW = 8;
  localparam int LN = 8;

  typedef struct {logic [CW-1:0] t; logic [4:0] line; logic [LN-1:0] len;} ent_t;
  typedef struct {int first; int last; int abort_at;} scen_t;
  typedef struct {logic [NL-1:0] irqs; logic fired; logic busy; logic done;} exp_t;
  typedef struct {int scen; int cyc; logic [NL-1:0] irqs; logic fired; logic done;} spot_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  irq_scheduler_if #(.NLINES(NL), .DEPTH(DP), .CNT_W(CW), .LEN_W(LN)) bus ();

  irq_scheduler #(.NLINES(NL), .DEPTH(DP), .CNT_W(CW), .LEN_W(LN), .DEF_PULSE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  ent_t  tbl [DP];
  scen_t sc [9];
  spot_t spots [21];
  exp_t  sb [$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    ncyc;
  int    m_fire [DP];
  int    m_line [DP];
  int    m_len [DP];
  int    m_nf;
  int    m_abort;
  logic [NL-1:0] rec_irqs [512];
  logic          rec_fired [512];
  logic          rec_done [512];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected irqs: each line follows the latest fire before cycle c on it.
  function automatic logic [NL-1:0] m_irqs(input int c);
    logic [NL-1:0] v;
    int lk;
    v = '0;
    for (int l = 0; l < NL; l++) begin
      lk = -1;
      for (int k = 0; k < m_nf; k++) if (m_line[k] == l && m_fire[k] < c) lk = k;
      if (lk >= 0 && c <= m_fire[lk] + m_len[lk]) v[l] = 1'b1;
    end
    if (m_abort >= 0 && c > m_abort) v = '0;
    return v;
  endfunction

  task automatic plan(input scen_t s);
    int prev, f, lf, c, d;
    logic stop, fd;
    exp_t e;
    prev = -1; m_nf = 0; m_abort = s.abort_at; stop = 1'b0;
    if (s.first <= s.last) begin
      for (int i = s.first; i <= s.last; i++) begin
        f = (int'(tbl[i].t) > prev + 1) ? int'(tbl[i].t) : prev + 1;
        if (m_abort >= 0 && f >= m_abort) stop = 1'b1;
        if (!stop) begin
          m_fire[m_nf] = f;
          m_line[m_nf] = int'(tbl[i].line);
          m_len[m_nf]  = (tbl[i].len == '0) ? 2 : int'(tbl[i].len);
          m_nf++;
          prev = f;
        end
      end
    end
    lf = (m_nf > 0) ? m_fire[m_nf-1] : -1;
    c = lf + 1;
    while (m_irqs(c) != '0 && c < 500) c++;
    d = c + 1;
    ncyc = (m_abort >= 0) ? m_abort + 3 : d + 2;
    for (int cy = 0; cy < ncyc; cy++) begin
      fd = 1'b0;
      for (int k = 0; k < m_nf; k++) if (m_fire[k] == cy - 1) fd = 1'b1;
      e.irqs  = m_irqs(cy);
      e.fired = fd;
      e.busy  = (m_abort >= 0) ? (cy <= m_abort) : (cy < d);
      e.done  = (m_abort < 0) && (cy >= d);
      sb.push_back(e);
    end
  endtask

  task automatic run_scen(input int si);
    exp_t e;
    plan(sc[si]);
    @(negedge clk);
    bus.first = 4'(sc[si].first);
    bus.last  = 4'(sc[si].last);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rec_irqs[c]  = bus.irqs;
      rec_fired[c] = bus.fired;
      rec_done[c]  = bus.done;
      if (sb.size() == 0) begin
        check($sformatf("scen%0d scoreboard underrun cycle%0d", si, c), 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("scen%0d cycle%0d {irqs,fired,busy,done}", si, c),
              64'({bus.irqs, bus.fired, bus.busy, bus.done}),
              64'({e.irqs, e.fired, e.busy, e.done}));
      end
      bus.abort = (c == sc[si].abort_at);
    end
    @(negedge clk);
    bus.abort = 1'b0;
    for (int k = 0; k < 21; k++) begin
      if (spots[k].scen == si && spots[k].cyc < ncyc) begin
        check($sformatf("scen%0d spot cycle%0d {irqs,fired,done}", si, spots[k].cyc),
              64'({rec_irqs[spots[k].cyc], rec_fired[spots[k].cyc], rec_done[spots[k].cyc]}),
              64'({spots[k].irqs, spots[k].fired, spots[k].done}));
      end
    end
  endtask

  initial begin
    tbl[0]  = '{8'd5,   5'd3,  8'd0};
    tbl[1]  = '{8'd4,   5'd1,  8'd3};
    tbl[2]  = '{8'd4,   5'd2,  8'd3};
    tbl[3]  = '{8'd4,   5'd1,  8'd3};
    tbl[4]  = '{8'd2,   5'd31, 8'd10};
    tbl[5]  = '{8'd3,   5'd7,  8'd5};
    tbl[6]  = '{8'd20,  5'd7,  8'd2};
    tbl[7]  = '{8'd255, 5'd0,  8'd1};
    tbl[8]  = '{8'd255, 5'd1,  8'd1};
    tbl[9]  = '{8'd255, 5'd2,  8'd1};
    tbl[10] = '{8'd0,   5'd4,  8'd4};
    tbl[11] = '{8'd0,   5'd5,  8'd1};
    tbl[12] = '{8'd6,   5'd9,  8'd8};
    tbl[13] = '{8'd7,   5'd9,  8'd1};
    tbl[14] = '{8'd1,   5'd0,  8'd1};
    tbl[15] = '{8'd1,   5'd0,  8'd1};

    sc = '{'{0, 0, -1}, '{1, 3, -1}, '{4, 4, 6}, '{4, 4, -1}, '{5, 4, -1},
           '{7, 9, -1}, '{10, 11, -1}, '{12, 13, -1}, '{5, 6, -1}};

    spots = '{
      '{0, 5, 32'h0, 1'b0, 1'b0}, '{0, 6, 32'h8, 1'b1, 1'b0}, '{0, 7, 32'h8, 1'b0, 1'b0},
      '{0, 8, 32'h0, 1'b0, 1'b0}, '{0, 9, 32'h0, 1'b0, 1'b1},
      '{1, 5, 32'h2, 1'b1, 1'b0}, '{1, 6, 32'h6, 1'b1, 1'b0}, '{1, 7, 32'h6, 1'b1, 1'b0},
      '{1, 9, 32'h2, 1'b0, 1'b0}, '{1, 10, 32'h0, 1'b0, 1'b0},
      '{2, 3, 32'h8000_0000, 1'b1, 1'b0}, '{2, 6, 32'h8000_0000, 1'b0, 1'b0},
      '{2, 7, 32'h0, 1'b0, 1'b0}, '{2, 8, 32'h0, 1'b0, 1'b0},
      '{4, 0, 32'h0, 1'b0, 1'b0}, '{4, 1, 32'h0, 1'b0, 1'b1},
      '{5, 256, 32'h1, 1'b1, 1'b0}, '{5, 257, 32'h2, 1'b1, 1'b0}, '{5, 258, 32'h4, 1'b1, 1'b0},
      '{5, 259, 32'h0, 1'b0, 1'b0}, '{5, 260, 32'h0, 1'b0, 1'b1}};

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_time = '0; bus.wr_line = '0; bus.wr_len = '0;
    bus.first = '0; bus.last = '0; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state {irqs,ptr,busy,done,fired}",
          64'({bus.irqs, bus.ptr, bus.busy, bus.done, bus.fired}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < DP; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 4'(i);
      bus.wr_time = tbl[i].t; bus.wr_line = tbl[i].line; bus.wr_len = tbl[i].len;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;

    for (int s = 0; s < 8; s++) run_scen(s);

    // Reset mid-pulse on line 7 with entry 6 still pending.
    bus.first = 4'd5; bus.last = 4'd6; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) check("pre-reset cycle3 irqs", 64'(bus.irqs), 64'h0);
      if (c == 4) check("pre-reset cycle4 irqs", 64'(bus.irqs), 64'h80);
      if (c == 5) check("pre-reset cycle5 {irqs,ptr}", 64'({bus.irqs, bus.ptr}), 64'({32'h80, 4'd6}));
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid-run reset {irqs,ptr,busy,done,fired}",
          64'({bus.irqs, bus.ptr, bus.busy, bus.done, bus.fired}), 64'd0);
    reset = 1'b0;
    run_scen(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
